ebu_rr_arbiter: RTL and testbench

Round-robin, burst-aware AHB-Lite address-phase arbiter for the external bus unit. It shares one AHB-Lite manager port between NREQ requesters, for example IFU, LSU and a future DMA or page-table walker. It issues a registered one-hot address grant, tracks the data-phase owner, and gates HREADY back to each requester. A grant is held for the full length of a fixed-length burst, and ownership changes only at burst boundaries.

---
 rtl/ebu_rr_arbiter_pkg.sv | 26 ++
 rtl/ebu_rr_arbiter_rrpriority.sv | 34 +++
 rtl/ebu_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_ebu_rr_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ebu_rr_arbiter_pkg.sv
// Shared EBU/AHB definitions: arbiter FSM states, HBURST encodings and the
// burst-length decode used by the arbiter and the cache bus FSMs.
package cvw;

    typedef enum logic {ARB_IDLE, ARB_OWN} ebuarbstate_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Undefined-length INCR is arbitrated as a single beat.
    function automatic logic [4:0] burstlen(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE, HBURST_INCR:  return 5'd1;
            HBURST_WRAP4,  HBURST_INCR4: return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8: return 5'd8;
            default:                     return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ebu_rr_arbiter_rrpriority.sv
// Rotating-priority one-hot picker: first set Req bit at or above Ptr,
// wrapping modulo N. Win is '0 when no request is set.
module rrpriority #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  Req,
    input  logic [IW-1:0] Ptr,
    output logic [N-1:0]  Win,
    output logic [IW-1:0] WinIdx
);

    int unsigned p;
    logic [IW-1:0] j;
    logic found;

    // Scan N positions starting at Ptr and keep the first requester seen.
    always_comb begin
        Win    = '0;
        WinIdx = '0;
        found  = 1'b0;
        p      = 32'(Ptr);
        j      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IW'((p + k) % N);
            if (!found && Req[j]) begin
                found  = 1'b1;
                Win[j] = 1'b1;
                WinIdx = j;
            end
        end
    end

endmodule

// File: rtl/ebu_rr_arbiter.sv
// Round-robin, burst-aware AHB-Lite address-phase arbiter for the EBU.
// Optional: define EBU_ARB_PRIO0_EN to give requester 0 (LSU) fixed top
// priority at every arbitration point; the others keep rotating.
module ebu_rr_arbiter
    import cvw::*;
#(
    parameter int NREQ = 3,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NREQ-1:0]   Req,
    input  logic [3*NREQ-1:0] ReqHBURST,
    input  logic              HREADY,
    output logic [NREQ-1:0]   Grant,
    output logic [IDXW-1:0]   GrantIdx,
    output logic [NREQ-1:0]   DataOwner,
    output logic [NREQ-1:0]   HREADYOut,
    output logic              BurstActive
);

    ebuarbstate_t state, nextstate;
    logic [IDXW-1:0] ptr, nextptr;
    logic [3:0]      beatcnt, nextbeatcnt;
    logic [NREQ-1:0] nextgrant, nextdataowner;
    logic [IDXW-1:0] nextgrantidx;
    logic            nextburstactive;

    logic [2:0]      hb [NREQ];
    logic [NREQ-1:0] reqscan, pickoh, winoh;
    logic [IDXW-1:0] pickidx, winidx;
    logic [4:0]      curlen;
    logic            beat, lastbeat, withdraw, arbpoint;

    for (genvar g = 0; g < NREQ; g++) begin : g_hb
        assign hb[g] = ReqHBURST[3*g +: 3];
    end

`ifdef EBU_ARB_PRIO0_EN
    // Requester 0 is handled outside the rotation; the picker sees only the rest.
    assign reqscan = {Req[NREQ-1:1], 1'b0};
`else
    assign reqscan = Req;
`endif

    rrpriority #(.N(NREQ), .IW(IDXW)) u_pick (
        .Req    (reqscan),
        .Ptr    (ptr),
        .Win    (pickoh),
        .WinIdx (pickidx)
    );

    assign HREADYOut = {NREQ{HREADY}} & (Grant | DataOwner);

    // State register; async reset abandons any burst and data phase in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            beatcnt     <= '0;
            Grant       <= '0;
            GrantIdx    <= '0;
            DataOwner   <= '0;
            BurstActive <= 1'b0;
        end else begin
            state       <= nextstate;
            ptr         <= nextptr;
            beatcnt     <= nextbeatcnt;
            Grant       <= nextgrant;
            GrantIdx    <= nextgrantidx;
            DataOwner   <= nextdataowner;
            BurstActive <= nextburstactive;
        end
    end

    // Beat accounting, arbitration points and next grant/owner selection.
    always_comb begin
        nextstate       = state;
        nextptr         = ptr;
        nextbeatcnt     = beatcnt;
        nextgrant       = Grant;
        nextgrantidx    = GrantIdx;
        nextdataowner   = DataOwner;
        nextburstactive = BurstActive;

`ifdef EBU_ARB_PRIO0_EN
        if (Req[0]) begin
            winoh  = NREQ'(1);
            winidx = '0;
        end else begin
            winoh  = pickoh;
            winidx = pickidx;
        end
`else
        winoh  = pickoh;
        winidx = pickidx;
`endif

        beat     = (|Grant) & Req[GrantIdx] & HREADY;
        curlen   = burstlen(hb[GrantIdx]);
        lastbeat = beat & ({1'b0, beatcnt} == (curlen - 5'd1));
        // Owner dropped its request before its first beat was taken.
        withdraw = (state == ARB_OWN) & ~Req[GrantIdx] & (beatcnt == '0);
        arbpoint = (state == ARB_IDLE) | lastbeat | withdraw;

        if (arbpoint) begin
            nextbeatcnt = '0;
            if (|winoh) begin
                nextstate       = ARB_OWN;
                nextgrant       = winoh;
                nextgrantidx    = winidx;
                nextburstactive = (burstlen(hb[winidx]) != 5'd1);
`ifdef EBU_ARB_PRIO0_EN
                // A priority win by requester 0 leaves the rotation untouched.
                if (!Req[0])
                    nextptr = (winidx == IDXW'(NREQ-1)) ? '0 : winidx + 1'b1;
`else
                nextptr = (winidx == IDXW'(NREQ-1)) ? '0 : winidx + 1'b1;
`endif
            end else begin
                nextstate       = ARB_IDLE;
                nextgrant       = '0;
                nextgrantidx    = '0;
                nextburstactive = 1'b0;
            end
        end else if (beat) begin
            nextbeatcnt = beatcnt + 4'd1;
        end

        if (HREADY)
            nextdataowner = beat ? Grant : '0;
    end

endmodule

// File: tb/tb_ebu_rr_arbiter.sv
// Directed bench for ebu_rr_arbiter (NREQ=3) with hand-computed expectations.
module tb_ebu_rr_arbiter;

    localparam int NREQ = 3;
    localparam int IDXW = 2;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [NREQ-1:0] Req;
    logic [3*NREQ-1:0] ReqHBURST;
    logic            HREADY;
    logic [NREQ-1:0] Grant;
    logic [IDXW-1:0] GrantIdx;
    logic [NREQ-1:0] DataOwner;
    logic [NREQ-1:0] HREADYOut;
    logic            BurstActive;

    int checks = 0;
    int errors = 0;
    logic [9:0] hrpat = 10'b1110111011;  // bit c = HREADY in grant cycle c

    always #5 HCLK = ~HCLK;

    ebu_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .Req         (Req),
        .ReqHBURST   (ReqHBURST),
        .HREADY      (HREADY),
        .Grant       (Grant),
        .GrantIdx    (GrantIdx),
        .DataOwner   (DataOwner),
        .HREADYOut   (HREADYOut),
        .BurstActive (BurstActive)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn   = 1'b0;
        Req       = '0;
        ReqHBURST = '0;
        HREADY    = 1'b1;
        step();
        step();
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_idx", 32'(GrantIdx), 0);
        chk("rst_owner", 32'(DataOwner), 0);
        chk("rst_active", 32'(BurstActive), 0);
        HRESETn = 1'b1;

`ifdef EBU_ARB_PRIO0_EN
        Req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("prio_grant", 32'(Grant), 32'b001);
        end
        // Requester 0 withdraws; requester 2 takes an INCR16.
        Req = 3'b100;
        ReqHBURST = {3'b111, 3'b000, 3'b000};
        step();
        Req = 3'b101;
        for (int i = 0; i < 16; i++) begin
            chk("prio_hold", 32'(Grant), 32'b100);
            chk("prio_active", 32'(BurstActive), 1);
            step();
        end
        chk("prio_after", 32'(Grant), 32'b001);
        chk("prio_after_owner", 32'(DataOwner), 32'b100);
`else
        // Round robin, all SINGLE.
        Req = 3'b111;
        step();
        chk("rr0_grant", 32'(Grant), 32'b001);
        chk("rr0_idx", 32'(GrantIdx), 0);
        chk("rr0_owner", 32'(DataOwner), 0);
        step();
        chk("rr1_grant", 32'(Grant), 32'b010);
        chk("rr1_idx", 32'(GrantIdx), 1);
        chk("rr1_owner", 32'(DataOwner), 32'b001);
        chk("rr1_hrdyout", 32'(HREADYOut), 32'b011);
        step();
        chk("rr2_grant", 32'(Grant), 32'b100);
        chk("rr2_idx", 32'(GrantIdx), 2);
        chk("rr2_owner", 32'(DataOwner), 32'b010);
        step();
        chk("rr3_grant", 32'(Grant), 32'b001);
        chk("rr3_owner", 32'(DataOwner), 32'b100);

        // Idle return: requester 0 re-wins, then everyone goes quiet.
        Req = 3'b001;
        step();
        chk("idle_regrant", 32'(Grant), 32'b001);
        chk("idle_regrant_owner", 32'(DataOwner), 32'b001);
        Req = 3'b000;
        step();
        chk("idle_grant", 32'(Grant), 0);
        chk("idle_idx", 32'(GrantIdx), 0);
        chk("idle_owner", 32'(DataOwner), 0);
        Req = 3'b111;
        step();
        chk("idle_ptr", 32'(Grant), 32'b010);

        // Burst hold: requester 1 INCR4 while requester 0 waits.
        Req = 3'b000;
        step();
        chk("hold_pre_idle", 32'(Grant), 0);
        Req = 3'b010;
        ReqHBURST = {3'b000, 3'b011, 3'b000};
        step();
        Req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            chk("hold_grant", 32'(Grant), 32'b010);
            chk("hold_active", 32'(BurstActive), 1);
            step();
        end
        chk("hold_next", 32'(Grant), 32'b001);
        chk("hold_next_active", 32'(BurstActive), 0);
        chk("hold_next_owner", 32'(DataOwner), 32'b010);

        // Wait states: requester 2 WRAP8, HREADY low on beats 3 and 6.
        Req = 3'b100;
        ReqHBURST = {3'b100, 3'b000, 3'b000};
        step();
        Req = 3'b101;
        for (int c = 0; c < 10; c++) begin
            HREADY = hrpat[c];
            #1;
            chk("wait_grant", 32'(Grant), 32'b100);
            chk("wait_hrdyout", 32'(HREADYOut), 32'({hrpat[c], 2'b00}));
            step();
        end
        HREADY = 1'b1;
        chk("wait_next", 32'(Grant), 32'b001);
        chk("wait_next_owner", 32'(DataOwner), 32'b100);

        // Async reset in the middle of an INCR4 from requester 1.
        Req = 3'b111;
        ReqHBURST = {3'b000, 3'b011, 3'b000};
        step();
        chk("mid_grant", 32'(Grant), 32'b010);
        step();
        #3;
        HRESETn = 1'b0;
        #1;
        chk("arst_grant", 32'(Grant), 0);
        chk("arst_idx", 32'(GrantIdx), 0);
        chk("arst_owner", 32'(DataOwner), 0);
        chk("arst_active", 32'(BurstActive), 0);
        chk("arst_hrdyout", 32'(HREADYOut), 0);
        Req = 3'b010;
        ReqHBURST = '0;
        #1;
        HRESETn = 1'b1;
        step();
        chk("post_rst_grant", 32'(Grant), 32'b010);
        chk("post_rst_idx", 32'(GrantIdx), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
